// File: rtl/fpu_sequencer.sv
// Issue/retire front end for the fp24 FPU. A latency-class slot tracker steers the
// free-running FPU pipelines, and retired results land in a tagged valid/ready FIFO.
module fpu_sequencer #(
  parameter int WIDTH     = 24,
  parameter int TAG_W     = 4,
  parameter int ADD_LAT   = 3,
  parameter int MUL_LAT   = 2,
  parameter int MISC_LAT  = 1,
  parameter int OUT_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_opcode,
  input  logic [TAG_W-1:0] in_tag,
  output logic [WIDTH-1:0] fpu_a,
  output logic [WIDTH-1:0] fpu_b,
  output logic [3:0]       fpu_opcode,
  input  logic [WIDTH-1:0] fpu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  localparam int MAXL  = (ADD_LAT > MUL_LAT) ? ((ADD_LAT > MISC_LAT) ? ADD_LAT : MISC_LAT)
                                             : ((MUL_LAT > MISC_LAT) ? MUL_LAT : MISC_LAT);
  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {CLS_ADD, CLS_MUL, CLS_MISC} cls_t;

  function automatic cls_t op_class(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0100: return CLS_ADD;
      4'b0011:                            return CLS_MUL;
      default:                            return CLS_MISC;
    endcase
  endfunction

  function automatic int class_lat(input cls_t c);
    case (c)
      CLS_ADD: return ADD_LAT;
      CLS_MUL: return MUL_LAT;
      default: return MISC_LAT;
    endcase
  endfunction

  // Any opcode of the class steers the FPU result mux to that line.
  function automatic logic [3:0] class_opcode(input cls_t c);
    case (c)
      CLS_ADD: return 4'b0000;
      CLS_MUL: return 4'b0011;
      default: return 4'b0101;
    endcase
  endfunction

  logic             slot_v [0:MAXL];
  cls_t             slot_c [0:MAXL];
  logic [TAG_W-1:0] slot_t [0:MAXL];

  logic [WIDTH+TAG_W-1:0] fifo_mem [0:OUT_DEPTH-1];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       fifo_count, count_next;

  cls_t in_cls;
  int   in_lat;
  int   inflight;
  logic target_busy, credit_ok, issue, push, pop;

  always_comb begin
    in_cls      = op_class(in_opcode);
    in_lat      = class_lat(in_cls);
    target_busy = 1'b0;
    inflight    = 0;
    for (int i = 0; i <= MAXL; i++) begin
      if (slot_v[i] && i == in_lat) target_busy = 1'b1;
      if (slot_v[i]) inflight = inflight + 1;
    end
    // A pop in this same cycle is deliberately not credited.
    credit_ok = (int'(fifo_count) + inflight) < OUT_DEPTH;
    in_ready  = rst_n && !target_busy && (!slot_v[0] || slot_c[0] == in_cls) && credit_ok;
    issue     = in_valid && in_ready;
  end

  always_comb begin
    fpu_a      = '0;
    fpu_b      = '0;
    fpu_opcode = 4'b0000;
    if (issue) begin
      fpu_a      = in_a;
      fpu_b      = in_b;
      fpu_opcode = in_opcode;
    end else if (slot_v[0]) begin
      fpu_opcode = class_opcode(slot_c[0]);
    end
  end

  assign push      = slot_v[0];
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  assign {out_result, out_tag} = out_valid ? fifo_mem[rd_ptr] : '0;

  always_comb begin
    count_next = fifo_count;
    if (push && !pop)      count_next = fifo_count + CNT_W'(1);
    else if (pop && !push) count_next = fifo_count - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= MAXL; i++) begin
        slot_v[i] <= 1'b0;
        slot_c[i] <= CLS_ADD;
        slot_t[i] <= '0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      busy       <= 1'b0;
    end else begin
      for (int i = 0; i < MAXL; i++) begin
        slot_v[i] <= slot_v[i+1];
        slot_c[i] <= slot_c[i+1];
        slot_t[i] <= slot_t[i+1];
      end
      slot_v[MAXL] <= 1'b0;
      slot_c[MAXL] <= CLS_ADD;
      slot_t[MAXL] <= '0;
      // Written one below its latency so it reaches slot 0 exactly L cycles out.
      if (issue) begin
        for (int i = 0; i < MAXL; i++) begin
          if (i == in_lat - 1) begin
            slot_v[i] <= 1'b1;
            slot_c[i] <= in_cls;
            slot_t[i] <= in_tag;
          end
        end
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count <= count_next;
      busy       <= ((inflight - int'(slot_v[0]) + int'(issue)) != 0) || (count_next != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {fpu_result, slot_t[0]};
  end

endmodule

// File: tb/tb_fpu_sequencer.sv
// Bench for fpu_sequencer: behavioural fp24 FPU stub, table vectors, directed
// corner sequences and a retire-ordered scoreboard under random traffic.
module tb_fpu_sequencer;
  localparam int WIDTH = 24;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] in_a, in_b;
  logic [3:0]       in_opcode;
  logic [TAG_W-1:0] in_tag;
  logic [WIDTH-1:0] fpu_a, fpu_b, fpu_result;
  logic [3:0]       fpu_opcode;
  logic             out_valid, out_ready, busy;
  logic [WIDTH-1:0] out_result;
  logic [TAG_W-1:0] out_tag;

  fpu_sequencer #(.WIDTH(WIDTH), .TAG_W(TAG_W), .ADD_LAT(3), .MUL_LAT(2), .MISC_LAT(1),
                  .OUT_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_opcode(in_opcode), .in_tag(in_tag),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_opcode(fpu_opcode), .fpu_result(fpu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic real to_real(input logic [23:0] x);
    logic [63:0] d;
    if (x[22:15] == 8'h00) return 0.0;
    d = {x[23], 11'(int'(x[22:15]) - 127 + 1023), x[14:0], 37'h0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [23:0] from_real(input real r);
    logic [63:0] d;
    int e;
    if (r == 0.0) return 24'h0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    if (e <= 0) return {d[63], 23'h0};
    if (e >= 255) return {d[63], 8'hFF, 15'h0};
    return {d[63], 8'(e), d[51:37]};
  endfunction

  function automatic logic [23:0] fpu_model(input logic [3:0] op, input logic [23:0] a,
                                            input logic [23:0] b);
    real ra, rb;
    ra = to_real(a);
    rb = to_real(b);
    case (op)
      4'b0000: return from_real(ra + rb);
      4'b0001: return from_real(ra - rb);
      4'b0010: return (ra < rb) ? a : b;
      4'b0100: return (ra > rb) ? a : b;
      4'b0011: return from_real(ra * rb);
      4'b0101: return {~a[23], a[22:0]};
      4'b0110: return {1'b0, a[22:0]};
      default: return a;
    endcase
  endfunction

  function automatic int op_lat(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0100: return 3;
      4'b0011: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic logic [23:0] rand_fp();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 15'($urandom)};
  endfunction

  // Free-running FPU stand-in: three lines, result mux steered by the live opcode.
  logic [WIDTH-1:0] add_p0, add_p1, add_p2, mul_p0, mul_p1, misc_p0;
  always @(posedge clk) begin
    add_p0  <= fpu_model(fpu_opcode, fpu_a, fpu_b);
    add_p1  <= add_p0;
    add_p2  <= add_p1;
    mul_p0  <= fpu_model(fpu_opcode, fpu_a, fpu_b);
    mul_p1  <= mul_p0;
    misc_p0 <= fpu_model(fpu_opcode, fpu_a, fpu_b);
  end
  always_comb begin
    case (op_lat(fpu_opcode))
      3:       fpu_result = add_p2;
      2:       fpu_result = mul_p1;
      default: fpu_result = misc_p0;
    endcase
  end

  typedef struct {
    int          retire;
    logic [23:0] res;
    logic [3:0]  tag;
  } exp_t;
  exp_t expq[$];

  typedef struct {
    logic [3:0]  op;
    logic [23:0] a;
    logic [23:0] b;
    logic [3:0]  tag;
    logic [23:0] res;
    int          lat;
  } vec_t;
  vec_t vecs[8];

  int total = 0, bad = 0;
  int n_issue = 0, n_out = 0, last_issue_cyc = 0, last_out_cyc = 0;
  logic [23:0] last_out_res = '0, hold_res = '0;
  logic [3:0]  last_out_tag = '0, hold_tag = '0;
  logic        hold = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, wanted %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e, t;
    logic clash;
    if (!rst_n) begin
      hold = 1'b0;
      return;
    end
    if (hold) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_result", 32'(out_result), 32'(hold_res));
      check("hold_tag", 32'(out_tag), 32'(hold_tag));
    end
    if (out_valid && out_ready) begin
      n_out++;
      last_out_cyc = cyc;
      last_out_res = out_result;
      last_out_tag = out_tag;
      if (expq.size() == 0) begin
        check("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        e = expq.pop_front();
        check("out_result", 32'(out_result), 32'(e.res));
        check("out_tag", 32'(out_tag), 32'(e.tag));
        if (cyc < e.retire + 1) check("out_too_early", cyc, e.retire + 1);
      end
    end
    hold     = out_valid && !out_ready;
    hold_res = out_result;
    hold_tag = out_tag;
    if (in_valid && in_ready) begin
      n_issue++;
      last_issue_cyc = cyc;
      check("fpu_drive_a", 32'(fpu_a), 32'(in_a));
      check("fpu_drive_op", 32'(fpu_opcode), 32'(in_opcode));
      e.retire = cyc + op_lat(in_opcode);
      e.res    = fpu_model(in_opcode, in_a, in_b);
      e.tag    = in_tag;
      clash = 1'b0;
      foreach (expq[i]) if (expq[i].retire == e.retire) clash = 1'b1;
      check("retire_clash", 32'(clash), 32'd0);
      expq.push_back(e);
      for (int i = expq.size() - 1; i > 0; i--) begin
        if (expq[i-1].retire > expq[i].retire) begin
          t = expq[i-1];
          expq[i-1] = expq[i];
          expq[i] = t;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_outs(input int target, input int budget);
    int k = 0;
    while (n_out < target && k < budget) begin
      tick();
      k++;
    end
    if (n_out < target) check("out_timeout", n_out, target);
  endtask

  task automatic issue_one(input logic [3:0] op, input logic [3:0] tag, input int budget);
    int n0 = n_issue;
    int k = 0;
    in_opcode = op; in_a = rand_fp(); in_b = rand_fp(); in_tag = tag; in_valid = 1'b1;
    while (n_issue == n0 && k < budget) begin
      tick();
      k++;
    end
    in_valid = 1'b0;
    if (n_issue == n0) check("issue_timeout", n_issue, n0 + 1);
  endtask

  initial begin
    int n0, acc, base;
    vecs[0] = '{4'b0000, 24'h3F8000, 24'h400000, 4'h5, 24'h404000, 4};
    vecs[1] = '{4'b0011, 24'h400000, 24'h404000, 4'h9, 24'h40C000, 3};
    vecs[2] = '{4'b0001, 24'h400000, 24'h3F8000, 4'h2, 24'h3F8000, 4};
    vecs[3] = '{4'b0101, 24'h3F8000, 24'h000000, 4'hA, 24'hBF8000, 2};
    vecs[4] = '{4'b0110, 24'hBF8000, 24'h000000, 4'h3, 24'h3F8000, 2};
    vecs[5] = '{4'b0010, 24'h400000, 24'h3F8000, 4'h7, 24'h3F8000, 4};
    vecs[6] = '{4'b0100, 24'h400000, 24'h3F8000, 4'hF, 24'h400000, 4};
    vecs[7] = '{4'b0111, 24'h123456, 24'h654321, 4'h1, 24'h123456, 2};

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_opcode = '0; in_tag = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fpu_opcode", 32'(fpu_opcode), 32'd0);
    check("rst_fpu_a", 32'(fpu_a), 32'd0);
    check("rst_out_result", 32'(out_result), 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    rst_n = 1'b1;
    #1;
    check("release_in_ready", 32'(in_ready), 32'd1);
    tick();

    // Single ops, one at a time, with a draining consumer.
    for (int k = 0; k < 8; k++) begin
      in_opcode = vecs[k].op; in_a = vecs[k].a; in_b = vecs[k].b; in_tag = vecs[k].tag;
      in_valid = 1'b1;
      #1;
      check($sformatf("vec%0d_ready", k), 32'(in_ready), 32'd1);
      n0 = n_out;
      tick();
      in_valid = 1'b0;
      check($sformatf("vec%0d_busy_hi", k), 32'(busy), 32'd1);
      wait_outs(n0 + 1, 10);
      check($sformatf("vec%0d_latency", k), last_out_cyc - last_issue_cyc, vecs[k].lat);
      check($sformatf("vec%0d_result", k), 32'(last_out_res), 32'(vecs[k].res));
      check($sformatf("vec%0d_tag", k), 32'(last_out_tag), 32'(vecs[k].tag));
      check($sformatf("vec%0d_busy_lo", k), 32'(busy), 32'd0);
    end

    // ADD then MUL next cycle would share a retire cycle.
    n0 = n_out;
    issue_one(4'b0000, 4'h1, 4);
    in_opcode = 4'b0011; in_a = rand_fp(); in_b = rand_fp(); in_tag = 4'h2; in_valid = 1'b1;
    #1;
    check("t2_mul_stall", 32'(in_ready), 32'd0);
    tick();
    check("t2_mul_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    wait_outs(n0 + 2, 10);
    check("t2_last_tag", 32'(last_out_tag), 32'd2);

    // MISC offered in the cycle an ADD retires.
    n0 = n_out;
    issue_one(4'b0000, 4'h3, 4);
    tick();
    tick();
    in_opcode = 4'b0101; in_a = rand_fp(); in_b = rand_fp(); in_tag = 4'h4; in_valid = 1'b1;
    #1;
    check("t3_misc_stall", 32'(in_ready), 32'd0);
    tick();
    check("t3_misc_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    wait_outs(n0 + 2, 10);
    check("t3_last_tag", 32'(last_out_tag), 32'd4);

    // Stream MUL ops into a stalled consumer.
    n0 = n_out; base = n_issue; acc = 0; out_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      in_opcode = 4'b0011; in_a = rand_fp(); in_b = rand_fp(); in_tag = 4'(acc);
      in_valid = 1'b1;
      tick();
      acc = n_issue - base;
    end
    check("t4_accepted", acc, 4);
    check("t4_ready_low", 32'(in_ready), 32'd0);
    check("t4_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 40 && acc < 8; k++) begin
      in_opcode = 4'b0011; in_a = rand_fp(); in_b = rand_fp(); in_tag = 4'(acc);
      in_valid = 1'b1;
      tick();
      acc = n_issue - base;
    end
    in_valid = 1'b0;
    wait_outs(n0 + 8, 20);
    check("t4_out_count", n_out - n0, 8);
    check("t4_queue_empty", expq.size(), 0);

    // Reset with results queued and ops in flight.
    out_ready = 1'b0;
    issue_one(4'b0101, 4'h1, 4);
    issue_one(4'b0101, 4'h2, 4);
    issue_one(4'b0000, 4'h3, 6);
    issue_one(4'b0000, 4'h4, 6);
    check("t5_pre_valid", 32'(out_valid), 32'd1);
    check("t5_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_async_valid", 32'(out_valid), 32'd0);
    check("t5_async_busy", 32'(busy), 32'd0);
    check("t5_async_ready", 32'(in_ready), 32'd0);
    check("t5_async_fpu_op", 32'(fpu_opcode), 32'd0);
    expq.delete();
    hold = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    n0 = n_out;
    repeat (8) tick();
    check("t5_no_stale", n_out, n0);
    check("t5_busy", 32'(busy), 32'd0);

    // Random traffic with backpressure.
    for (int k = 0; k < 10000; k++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_opcode = 4'($urandom);
      in_a      = rand_fp();
      in_b      = rand_fp();
      in_tag    = 4'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 50 && expq.size() != 0; k++) tick();
    tick();
    check("rand_drained", expq.size(), 0);
    check("rand_busy", 32'(busy), 32'd0);
    check("rand_out_valid", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
